// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard; x0 hardwired to zero.
// Optional same-cycle writeback-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_addr,
  output logic                           issue_ready,
  input  logic                           wb_valid,
  input  logic [ADDR_WIDTH-1:0]          wb_addr,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  output logic [ADDR_WIDTH:0]            pending_count,
  output logic [DATA_WIDTH-1:0]          a0
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;
  logic [ADDR_WIDTH:0]   pending_reg;
  logic [ADDR_WIDTH:0]   pending_next;
  logic                  wb_en;
  logic                  issue_fire;

  assign wb_en       = wb_valid && (wb_addr != '0);
  // A writeback retiring the same register frees it for re-issue in the same cycle.
  assign issue_ready = !busy_reg[issue_addr]
                     || (wb_valid && (wb_addr == issue_addr))
                     || (issue_addr == '0);
  assign issue_fire  = issue_valid && issue_ready && (issue_addr != '0);

  always_comb begin
    busy_next    = busy_reg;
    pending_next = '0;
    if (wb_en)      busy_next[wb_addr]    = 1'b0;
    // Issue applied after the clear so a new pending write wins over a retiring one.
    if (issue_fire) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_next = pending_next + (ADDR_WIDTH+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy_reg    <= '0;
      pending_reg <= '0;
    end else begin
      if (wb_en) regs[wb_addr] <= wb_data;
      busy_reg    <= busy_next;
      pending_reg <= pending_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
      logic hit;
      assign hit = wb_en && (wb_addr == addr);
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = hit ? wb_data : regs[addr];
      assign rd_busy[gi] = hit ? 1'b0 : busy_reg[addr];
`else
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = regs[addr];
      assign rd_busy[gi] = busy_reg[addr];
`endif
    end
  endgenerate

  assign pending_count = pending_reg;
  assign a0            = regs[10];
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREGS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              issue_ready;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic [AW:0]       pending_count;
  logic [DW-1:0]     a0;

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending_count(pending_count), .a0(a0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural values and the set of registers awaiting writeback.
  logic [DW-1:0] m_regs [NREGS];
  bit            m_busy [NREGS];
  bit            model_ok = 0;

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  function automatic bit m_ready(input int ia, input bit wv, input int wa);
    if (ia == 0) return 1;
    if (!m_busy[ia]) return 1;
    return wv && (wa == ia);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 0;
      end
      model_ok = 1;
    end else if (model_ok) begin
      bit go;
      go = issue_valid && m_ready(int'(issue_addr), wb_valid, int'(wb_addr));
      if (wb_valid && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 0;
      end
      if (go && issue_addr != 0) m_busy[issue_addr] = 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < NR; k++) begin
        int a;
        logic [DW-1:0] ed;
        bit eb;
        a  = int'(rd_addr[k*AW +: AW]);
        ed = m_regs[a];
        eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && a != 0 && int'(wb_addr) == a) begin
          ed = wb_data;
          eb = 0;
        end
`endif
        chk($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DW +: DW]), 64'(ed));
        chk($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(eb));
      end
      chk("issue_ready", 64'(issue_ready),
          64'(m_ready(int'(issue_addr), wb_valid, int'(wb_addr))));
      chk("pending_count", 64'(pending_count), 64'(m_pending()));
      chk("a0", 64'(a0), 64'(m_regs[10]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue_valid = 0; issue_addr = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    rst = 1; rd_addr = '0; idle();
    step(); step();
    rst = 0;
    #1;
    chk("lit_reset_pending", 64'(pending_count), 64'd0);
    chk("lit_reset_ready", 64'(issue_ready), 64'd1);
    chk("lit_reset_a0", 64'(a0), 64'd0);
    for (int i = 0; i < NREGS; i++) begin
      set_rd(0, i); set_rd(1, NREGS-1-i);
      #1;
      chk("lit_reset_rd", 64'(rd_data[DW-1:0]), 64'd0);
      chk("lit_reset_busy", 64'(rd_busy), 64'd0);
      step();
    end

    // wb x10, then x0 must stay zero
    wb_valid = 1; wb_addr = 10; wb_data = 32'hDEADBEEF;
    $display("txn wb x10 = deadbeef");
    step();
    wb_addr = 0; wb_data = 32'h1234; set_rd(0, 10); set_rd(1, 0);
    $display("txn wb x0 = 1234");
    step();
    idle(); #1;
    chk("lit_x10_rd", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    chk("lit_a0", 64'(a0), 64'hDEADBEEF);
    chk("lit_x0_rd", 64'(rd_data[2*DW-1:DW]), 64'd0);

    // back-to-back issue to x5 stalls until its writeback
    issue_valid = 1; issue_addr = 5; set_rd(0, 5);
    $display("txn issue x5");
    step(); #1;
    chk("lit_x5_stall", 64'(issue_ready), 64'd0);
    chk("lit_x5_busy", 64'(rd_busy[0]), 64'd1);
    chk("lit_x5_pending", 64'(pending_count), 64'd1);
    step();
    wb_valid = 1; wb_addr = 5; wb_data = 32'd7; #1;
    $display("txn wb x5 = 7 with issue x5 pending");
    chk("lit_x5_wb_ready", 64'(issue_ready), 64'd1);
    step();
    idle(); #1;
    chk("lit_x5_still_busy", 64'(rd_busy[0]), 64'd1);
    chk("lit_x5_data", 64'(rd_data[DW-1:0]), 64'd7);
    chk("lit_x5_pending2", 64'(pending_count), 64'd1);

    // same-cycle writeback and read of x3 (x3 made busy holding 0x11 first)
    wb_valid = 1; wb_addr = 3; wb_data = 32'h11; step();
    idle(); issue_valid = 1; issue_addr = 3; step();
    idle(); set_rd(1, 3);
    wb_valid = 1; wb_addr = 3; wb_data = 32'h55; #1;
    $display("txn wb x3 = 55 with same-cycle read");
`ifdef REGFILE_BYPASS_EN
    chk("lit_x3_byp_data", 64'(rd_data[2*DW-1:DW]), 64'h55);
    chk("lit_x3_byp_busy", 64'(rd_busy[1]), 64'd0);
`else
    chk("lit_x3_nobyp_data", 64'(rd_data[2*DW-1:DW]), 64'h11);
    chk("lit_x3_nobyp_busy", 64'(rd_busy[1]), 64'd1);
`endif
    step(); idle(); #1;
    chk("lit_x3_after", 64'(rd_data[2*DW-1:DW]), 64'h55);
    chk("lit_x3_after_busy", 64'(rd_busy[1]), 64'd0);

    // drain x5, then fill every register
    wb_valid = 1; wb_addr = 5; wb_data = 32'd9; step(); idle();
    for (int i = 1; i < NREGS; i++) begin
      issue_valid = 1; issue_addr = AW'(i); step();
    end
    idle(); #1;
    $display("txn issued x1..x31");
    chk("lit_full_pending", 64'(pending_count), 64'd31);
    for (int i = 1; i < 12; i++) begin
      issue_valid = 1; issue_addr = AW'(i); step();
    end
    idle(); step();
    for (int i = 1; i < 12; i++) begin
      wb_valid = 1; wb_addr = AW'(i); wb_data = 32'(i); step();
    end
    idle();
    issue_valid = 1; issue_addr = 20;
    rst = 1; step(); rst = 0; idle(); set_rd(0, 7); set_rd(1, 10); #1;
    $display("txn reset mid-operation");
    chk("lit_rst_pending", 64'(pending_count), 64'd0);
    chk("lit_rst_ready", 64'(issue_ready), 64'd1);
    chk("lit_rst_rd", 64'(rd_data), 64'd0);

    // issue to x0 is accepted and ignored
    issue_valid = 1; issue_addr = 0; set_rd(0, 0); #1;
    chk("lit_x0_ready", 64'(issue_ready), 64'd1);
    step(); idle(); #1;
    $display("txn issue x0");
    chk("lit_x0_pending", 64'(pending_count), 64'd0);
    chk("lit_x0_busy", 64'(rd_busy[0]), 64'd0);

    // randomized traffic, writebacks biased toward registers still pending
    for (int c = 0; c < 3000; c++) begin
      int wa;
      rst = ($urandom_range(0, 299) == 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_addr  = AW'($urandom_range(0, 31));
      wb_valid    = ($urandom_range(0, 1) != 0);
      wa = $urandom_range(0, 31);
      for (int t = 0; t < 4 && !m_busy[wa]; t++) wa = $urandom_range(0, 31);
      wb_addr = AW'(wa);
      wb_data = $urandom;
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 3) == 0) set_rd(k, wa);
        else set_rd(k, $urandom_range(0, 31));
      end
      step();
    end
    rst = 0; idle(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in scoreboard for the pipelined RISC-V core. It provides NUM_RD combinational read ports and one writeback port, and hardwires x0 to zero. A per-register busy bit tracks in-flight destinations, so decode can detect RAW hazards and stall issue on WAW hazards through a valid/ready handshake. It sits between decode (reads, issue) and writeback (write, busy clear), and exports a0 for the testbench and display.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports, 1..4

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_WIDTH  read indices; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  read data, packed the same way
- rd_busy  out  NUM_RD  port k's register has a pending write (RAW hazard)
- issue_valid  in  1  decode requests to mark issue_addr pending
- issue_addr  in  ADDR_WIDTH  destination being issued
- issue_ready  out  1  issue accepted this cycle
- wb_valid  in  1  writeback strobe
- wb_addr  in  ADDR_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback value
- pending_count  out  ADDR_WIDTH+1  number of busy registers
- a0  out  DATA_WIDTH  architectural x10, registered value

## Operation
- Storage: regs[0..NUM_REGS-1] and busy[0..NUM_REGS-1].
- Reset (rst high at posedge): all regs = 0, all busy = 0, so pending_count = 0. Outputs after reset: rd_data = 0, rd_busy = 0, issue_ready = 1, a0 = 0. Reset overrides any concurrent issue or wb. Asserting reset mid-operation discards all pending entries.
- x0: never written, never busy. wb or issue to index 0 is accepted and ignored. Reads of index 0 return 0 with rd_busy = 0.
- Write: if wb_valid and wb_addr != 0, then regs[wb_addr] <= wb_data and busy[wb_addr] <= 0.
- Issue handshake: issue_ready = !busy[issue_addr] || (wb_valid && wb_addr == issue_addr) || issue_addr == 0.
  - A transfer occurs when issue_valid && issue_ready. It sets busy[issue_addr] <= 1 (skipped for x0).
  - issue_ready does not depend on issue_valid.
  - Decode holds issue_valid/issue_addr stable until the transfer.
- Simultaneous wb and issue to the same nonzero index: data is written and busy ends set (new pending write wins).
- A wb to a non-busy register is legal: the data is written and busy stays 0.
- pending_count is the registered popcount of busy after each update. Maximum value is NUM_REGS-1.
- Reads are combinational from regs/busy, subject to the bypass configuration below.
- a0 = regs[10], never bypassed.

## Timing
- Read: 0-cycle combinational from rd_addr.
- Write: visible in regs one cycle after the wb_valid edge.
- Issue: busy is visible on rd_busy/issue_ready the cycle after the transfer.
- Back-to-back issue to the same register stalls (issue_ready = 0) until the wb cycle for that register, in which issue_ready is already 1.
- Throughput: one issue and one wb per cycle.

## Configuration
- REGFILE_BYPASS_EN defined (write-first): if wb_valid && wb_addr == rd_addr[k] && rd_addr[k] != 0, then rd_data[k] = wb_data and rd_busy[k] = 0 in the same cycle.
- REGFILE_BYPASS_EN undefined: rd_data[k] returns the stored value, and rd_busy[k] remains 1 during the wb cycle. The new value and busy = 0 appear the next cycle.

## Test plan
- Reset then read all 32 indices -> rd_data = 0, rd_busy = 0, pending_count = 0, a0 = 0.
- wb x10 = 0xDEADBEEF, then read x10 next cycle -> rd_data = 0xDEADBEEF, a0 = 0xDEADBEEF. wb x0 = 0x1234 -> x0 still reads 0.
- Issue x5, then next cycle issue x5 again -> issue_ready = 0, rd_busy = 1 for a read of x5, pending_count = 1. Then wb x5 = 7 -> issue_ready = 1 that cycle; the second issue transfers and x5 remains busy, reads 7, pending_count = 1.
- Same-cycle wb x3 = 0x55 and read x3 -> with REGFILE_BYPASS_EN: rd_data = 0x55, rd_busy = 0. Without it: old value and rd_busy = 1 that cycle, then 0x55 next cycle.
- Issue x1..x31 on consecutive cycles -> pending_count = 31. Assert rst mid-sequence -> next cycle pending_count = 0, all regs 0, issue_ready = 1.
- Issue to x0 -> issue_ready = 1, pending_count unchanged, rd_busy for x0 = 0.
